// File: rtl/ibex_rf_write_arbiter.sv
// Register file write-port arbiter: merges late load data with in-order execute results,
// buffers displaced execute beats, and flags read operands that hit pending writes.
module ibex_rf_write_arbiter #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    function automatic logic [4:0] mask_addr(input logic [4:0] a);
        return RV32E ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [4:0]           fifo_addr_q [FifoDepth];
    logic [DataWidth-1:0] fifo_data_q [FifoDepth];
    logic [FifoDepth-1:0] fifo_vld_q;
    logic [PtrW-1:0]      rptr_q, wptr_q;
    logic [CntW-1:0]      count_q, count_d;

    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

    logic [4:0] ex_addr, lsu_addr, ra_addr, rb_addr;
    logic       ex_accept, ex_direct, fifo_push, fifo_pop, fifo_empty;
    logic       lsu_fifo_hit, lsu_drop, fifo_hit_a, fifo_hit_b;

    assign ex_addr  = mask_addr(ex_waddr_i);
    assign lsu_addr = mask_addr(lsu_waddr_i);
    assign ra_addr  = mask_addr(raddr_a_i);
    assign rb_addr  = mask_addr(raddr_b_i);

    assign fifo_empty = (count_q == '0);
    assign ex_ready_o = (count_q < CntW'(FifoDepth));
    assign ex_accept  = ex_valid_i && ex_ready_o;

    // A direct ex write only when nothing older is queued keeps execute writes in order.
    assign ex_direct = !lsu_valid_i && fifo_empty && ex_accept;
    assign fifo_pop  = !lsu_valid_i && !fifo_empty;
    assign fifo_push = ex_accept && !ex_direct;

    always_comb begin
        lsu_fifo_hit = 1'b0;
        fifo_hit_a   = 1'b0;
        fifo_hit_b   = 1'b0;
        for (int unsigned i = 0; i < FifoDepth; i++) begin
            if (fifo_vld_q[i]) begin
                if (fifo_addr_q[i] == lsu_addr) lsu_fifo_hit = 1'b1;
                if (fifo_addr_q[i] == ra_addr)  fifo_hit_a   = 1'b1;
                if (fifo_addr_q[i] == rb_addr)  fifo_hit_b   = 1'b1;
            end
        end
    end

    // A queued or same-cycle execute result to the same register is newer than the load.
    assign lsu_drop = lsu_fifo_hit || (ex_accept && (ex_addr == lsu_addr));

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (lsu_valid_i) begin
            if (!lsu_drop && (lsu_addr != '0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = lsu_addr;
                rf_wdata_d = lsu_wdata_i;
            end
        end else if (!fifo_empty) begin
            if (fifo_addr_q[rptr_q] != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = fifo_addr_q[rptr_q];
                rf_wdata_d = fifo_data_q[rptr_q];
            end
        end else if (ex_accept) begin
            if (ex_addr != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = ex_addr;
                rf_wdata_d = ex_wdata_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_vld_q <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (fifo_pop) begin
                fifo_vld_q[rptr_q] <= 1'b0;
                rptr_q             <= next_ptr(rptr_q);
            end
            if (fifo_push) begin
                fifo_addr_q[wptr_q] <= ex_addr;
                fifo_data_q[wptr_q] <= ex_wdata_i;
                fifo_vld_q[wptr_q]  <= 1'b1;
                wptr_q              <= next_ptr(wptr_q);
            end
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    assign hazard_a_o = (ra_addr != '0) && (fifo_hit_a || (rf_we_q && (rf_waddr_q == ra_addr)));
    assign hazard_b_o = (rb_addr != '0) && (fifo_hit_b || (rf_we_q && (rf_waddr_q == rb_addr)));
    assign busy_o     = !fifo_empty || rf_we_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Scoreboard bench for ibex_rf_write_arbiter: stimulus queues expected register writes,
// a negedge monitor pops and compares every rf_we_o strobe.
module tb_ibex_rf_write_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, lsu_valid_i;
    logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
    logic [31:0] ex_wdata_i, lsu_wdata_i;
    logic        ex_ready_o, rf_we_o, hazard_a_o, hazard_b_o, busy_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    wr_t e;

    ibex_rf_write_arbiter #(
        .RV32E    (1'b1),
        .DataWidth(32),
        .FifoDepth(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ex_valid_i (ex_valid_i),
        .ex_ready_o (ex_ready_o),
        .ex_waddr_i (ex_waddr_i),
        .ex_wdata_i (ex_wdata_i),
        .lsu_valid_i(lsu_valid_i),
        .lsu_waddr_i(lsu_waddr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .rf_we_o    (rf_we_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o),
        .raddr_a_i  (raddr_a_i),
        .raddr_b_i  (raddr_b_i),
        .hazard_a_o (hazard_a_o),
        .hazard_b_o (hazard_b_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni && rf_we_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%0d data=%08h, expected no write",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr_o !== e.addr || rf_wdata_o !== e.data) begin
                    bad++;
                    $display("FAIL wr_data: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                             rf_waddr_o, rf_wdata_o, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic idle_inputs();
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
        ex_waddr_i  = '0;
        ex_wdata_i  = '0;
        lsu_waddr_i = '0;
        lsu_wdata_i = '0;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] a, input logic [31:0] d);
        ex_valid_i = v;
        ex_waddr_i = a;
        ex_wdata_i = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_valid_i = v;
        lsu_waddr_i = a;
        lsu_wdata_i = d;
    endtask

    initial begin
        idle_inputs();
        raddr_a_i = '0;
        raddr_b_i = '0;
        rst_ni    = 1'b0;
        tick();
        tick();
        chk("rst_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_ready", ex_ready_o, 1);
        chk("rst_haz_a", hazard_a_o, 0);
        chk("rst_haz_b", hazard_b_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single direct execute write, one-cycle latency.
        set_ex(1'b1, 5'd5, 32'hA5A5_0001);
        expect_wr(5'd5, 32'hA5A5_0001);
        chk("t1_ready", ex_ready_o, 1);
        tick();
        idle_inputs();
        chk("t1_we", rf_we_o, 1);
        chk("t1_busy_hi", busy_o, 1);
        tick();
        chk("t1_we_lo", rf_we_o, 0);
        chk("t1_busy_lo", busy_o, 0);

        // Load wins the slot, execute beat goes through the FIFO.
        raddr_a_i = 5'd7;
        set_lsu(1'b1, 5'd3, 32'h1111);
        set_ex(1'b1, 5'd7, 32'h2222);
        expect_wr(5'd3, 32'h1111);
        expect_wr(5'd7, 32'h2222);
        tick();
        idle_inputs();
        chk("t2_haz_c1", hazard_a_o, 1);
        chk("t2_busy_c1", busy_o, 1);
        tick();
        chk("t2_haz_c2", hazard_a_o, 1);
        tick();
        chk("t2_haz_c3", hazard_a_o, 0);
        raddr_a_i = '0;

        // Fill the FIFO behind a 3-cycle load burst, then drain in order.
        expect_wr(5'd1, 32'h101);
        expect_wr(5'd2, 32'h102);
        expect_wr(5'd3, 32'h103);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd11, 32'hB0);
        expect_wr(5'd12, 32'hC0);
        raddr_b_i = 5'd11;
        set_lsu(1'b1, 5'd1, 32'h101);
        set_ex(1'b1, 5'd10, 32'hA0);
        tick();
        set_lsu(1'b1, 5'd2, 32'h102);
        set_ex(1'b1, 5'd11, 32'hB0);
        tick();
        set_lsu(1'b1, 5'd3, 32'h103);
        set_ex(1'b1, 5'd12, 32'hC0);
        chk("t3_ready_full", ex_ready_o, 0);
        chk("t3_haz_b", hazard_b_o, 1);
        tick();
        set_lsu(1'b0, 5'd0, 32'h0);
        chk("t3_ready_full2", ex_ready_o, 0);
        tick();
        chk("t3_ready_back", ex_ready_o, 1);
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        chk("t3_busy_end", busy_o, 0);
        raddr_b_i = '0;

        // Load to a register with a newer queued execute result is dropped.
        set_lsu(1'b1, 5'd4, 32'h44);
        set_ex(1'b1, 5'd9, 32'hBEEF);
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd9, 32'hBEEF);
        tick();
        set_ex(1'b0, 5'd0, 32'h0);
        set_lsu(1'b1, 5'd9, 32'hDEAD);
        tick();
        set_lsu(1'b0, 5'd0, 32'h0);
        chk("t4_drop_we", rf_we_o, 0);
        tick();
        tick();
        chk("t4_busy_end", busy_o, 0);

        // Same-cycle execute beat to the load's register also suppresses the load.
        set_lsu(1'b1, 5'd6, 32'hDEAD);
        set_ex(1'b1, 5'd6, 32'h6666);
        expect_wr(5'd6, 32'h6666);
        tick();
        idle_inputs();
        chk("t4b_drop_we", rf_we_o, 0);
        tick();
        tick();

        // x0 writes are consumed silently.
        set_ex(1'b1, 5'd0, 32'hFFFF);
        chk("t5_ready", ex_ready_o, 1);
        tick();
        idle_inputs();
        chk("t5_ex_x0_we", rf_we_o, 0);
        chk("t5_ex_x0_waddr", rf_waddr_o, 6);
        set_lsu(1'b1, 5'd0, 32'hEEEE);
        tick();
        idle_inputs();
        chk("t5_lsu_x0_we", rf_we_o, 0);
        raddr_a_i = 5'd0;
        set_lsu(1'b1, 5'd5, 32'h55);
        set_ex(1'b1, 5'd0, 32'h1234);
        expect_wr(5'd5, 32'h55);
        tick();
        idle_inputs();
        chk("t5_haz_x0", hazard_a_o, 0);
        chk("t5_busy_q", busy_o, 1);
        tick();
        chk("t5_pop_x0_we", rf_we_o, 0);
        chk("t5_busy_end", busy_o, 0);

        // RV32E ignores address bit 4.
        set_ex(1'b1, 5'b10011, 32'h33);
        expect_wr(5'b00011, 32'h33);
        tick();
        idle_inputs();
        chk("t6_waddr_e", rf_waddr_o, 5'b00011);
        tick();

        // Asynchronous reset with a full FIFO.
        raddr_a_i = 5'd10;
        set_lsu(1'b1, 5'd1, 32'h201);
        set_ex(1'b1, 5'd10, 32'h2A0);
        expect_wr(5'd1, 32'h201);
        expect_wr(5'd2, 32'h202);
        tick();
        set_lsu(1'b1, 5'd2, 32'h202);
        set_ex(1'b1, 5'd11, 32'h2B0);
        tick();
        idle_inputs();
        chk("t6_full_ready", ex_ready_o, 0);
        chk("t6_full_haz", hazard_a_o, 1);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_we", rf_we_o, 0);
        chk("t6_rst_waddr", rf_waddr_o, 0);
        chk("t6_rst_wdata", rf_wdata_o, 0);
        chk("t6_rst_haz", hazard_a_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("t6_post_ready", ex_ready_o, 1);
        chk("t6_post_we", rf_we_o, 0);
        tick();
        chk("t6_post_busy", busy_o, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibex_rf_write_arbiter.md
Name: ibex_rf_write_arbiter

Overview:
Writer-side front end for the latch-based register file's single write port. Merges two writeback sources: in-order execute results with a valid/ready handshake, and late load data that is always accepted and has priority. Execute results displaced by load data are buffered in a small FIFO. Emits registered write strobe, address and data to the register file, plus per-read-port hazard flags so operand readers stall on pending writes.

Parameters:
RV32E, 0, 1 = 16 registers; only waddr/raddr bit [3:0] are compared and driven, bit 4 is ignored on inputs and driven 0 on rf_waddr_o.
DataWidth, 32, write data width.
FifoDepth, 2, execute-result skid FIFO entries; legal range 1..4.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_valid_i  in  1  execute result valid
ex_ready_o  out  1  execute result accepted when high with ex_valid_i
ex_waddr_i  in  5  execute destination register
ex_wdata_i  in  DataWidth  execute result data
lsu_valid_i  in  1  load writeback valid; always accepted, no ready
lsu_waddr_i  in  5  load destination register
lsu_wdata_i  in  DataWidth  load data
rf_we_o  out  1  register file write enable (registered)
rf_waddr_o  out  5  register file write address (registered)
rf_wdata_o  out  DataWidth  register file write data (registered)
raddr_a_i  in  5  read port A address
raddr_b_i  in  5  read port B address
hazard_a_o  out  1  pending write to raddr_a_i
hazard_b_o  out  1  pending write to raddr_b_i
busy_o  out  1  FIFO non-empty or rf_we_o high

Behaviour:
- Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, FIFO empty (count=0), ex_ready_o=1, hazard_a/b_o=0, busy_o=0.
- ex_ready_o = (count < FifoDepth). It is a function of registered count only and does not depend on ex_valid_i or lsu_valid_i.
- Source select per cycle, with a fixed priority:
  1. lsu_valid_i
  2. FIFO head
  3. Accepted ex beat direct.
- A direct ex write is allowed only when the FIFO is empty, which preserves in-order execute writes.
- Accepted ex beat not selected for writing is pushed to the FIFO tail. Push and pop in the same cycle keep count unchanged.
- Chosen write is registered: rf_we_o/waddr/wdata update on the next clock edge, giving 1-cycle latency from acceptance. rf_we_o returns to 0 in cycles with no selected write.
- Writes to x0 are consumed (accepted/popped) but produce rf_we_o=0, and rf_waddr_o/rf_wdata_o hold their previous values.
- Load-vs-newer-execute ordering: if lsu_valid_i and lsu_waddr_i matches any valid FIFO entry, or the ex beat accepted the same cycle, the load write is dropped (rf_we_o=0 that cycle). The execute value is newer and wins.
- Hazards: hazard_x_o=1 iff raddr_x_i≠0 and it matches a valid FIFO entry address, or (rf_we_o && rf_waddr_o==raddr_x_i). Hazards are combinational from registered state only.
- busy_o = (count≠0) || rf_we_o.
- FIFO is a circular buffer; read/write pointers wrap modulo FifoDepth. Count never exceeds FifoDepth because ex_valid_i while ex_ready_o=0 is not accepted and ex inputs must be held.
- Reset asserted mid-operation: all FIFO entries discarded, outputs return to reset values asynchronously, and no write strobe is generated.

Test Plan:
- Reset, then ex_valid=1 waddr=5 data=0xA5A5_0001 -> next cycle rf_we=1 waddr=5 wdata=0xA5A5_0001, then rf_we=0; busy high exactly 1 cycle.
- Same cycle lsu(waddr=3, 0x1111) and ex(waddr=7, 0x2222) -> cycle+1 writes x3=0x1111, cycle+2 writes x7=0x2222; hazard_a=1 for raddr_a=7 during cycles +1 and +2.
- FifoDepth=2, lsu_valid held 3 cycles with ex_valid held -> ex_ready drops to 0 after 2 pushes; after lsu ends, the queued entries drain in order, then the held beat writes; no loss or duplication.
- ex waddr=9 0xBEEF queued behind lsu, then lsu waddr=9 0xDEAD -> load write suppressed; final x9 write is 0xBEEF.
- ex and lsu writes to x0 -> no rf_we; handshakes complete; hazard_a=0 for raddr_a=0.
- RV32E=1, ex waddr=5'b10011 -> rf_waddr=5'b00011; assert rst_ni with FIFO full -> all outputs 0 immediately, ex_ready=1 after release.
